// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC selection and the IF/ID register.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clkF,
  input  logic        rstF,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic        JumpD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCjumpD,
  input  logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] instrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] StallCntF,
  output logic [31:0] FlushCntF
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4_s;
  logic [31:0] next_pc_s;
  logic        redirect_s;

  // Next-PC selection and IF/ID update; a redirect discards the wrong-path word
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    redirect_s = PCSrcD | JumpD;
    if (JumpD) begin
      next_pc_s = PCjumpD;
    end else if (PCSrcD) begin
      next_pc_s = PCBranchD;
    end else begin
      next_pc_s = pc_plus4_s;
    end

    if (StallF) begin
      pc_d = pc_q;
    end else begin
      pc_d = next_pc_s;
    end

    if (StallD) begin
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
    end else if (redirect_s) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'h0000_0000;
      valid_d    = 1'b0;
    end else begin
      instr_d    = InstrF;
      pc_plus4_d = pc_plus4_s;
      valid_d    = 1'b1;
    end
  end

  // PC and IF/ID pipeline register
  always_ff @(posedge clkF or negedge rstF) begin
    if (!rstF) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign PCF      = pc_q;
  assign instrD   = instr_q;
  assign PCPlus4D = pc_plus4_q;
  assign ValidD   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: stalled fetch cycles and flushes actually applied
  always_comb begin
    if (StallF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (redirect_s && !StallD && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge clkF or negedge rstF) begin
    if (!rstF) begin
      stall_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCntF = stall_cnt_q;
  assign FlushCntF = flush_cnt_q;
`else
  assign StallCntF = 32'h0000_0000;
  assign FlushCntF = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; counter expectations follow FETCH_PERF_CNT_EN.
module tb_fetch_stage;

  logic        clkF;
  logic        rstF;
  logic        StallF, StallD, PCSrcD, JumpD;
  logic [31:0] PCBranchD, PCjumpD, InstrF;
  logic [31:0] PCF, instrD, PCPlus4D, StallCntF, FlushCntF;
  logic        ValidD;

  int total = 0;
  int bad   = 0;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_stage dut (
    .clkF(clkF), .rstF(rstF), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .JumpD(JumpD), .PCBranchD(PCBranchD), .PCjumpD(PCjumpD),
    .InstrF(InstrF), .PCF(PCF), .instrD(instrD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .StallCntF(StallCntF), .FlushCntF(FlushCntF)
  );

  // Combinational instruction memory: word at address a is a ^ 32'hA500_0000
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  assign InstrF = mem_word(PCF);

  initial begin
    clkF = 1'b0;
    forever #5 clkF = ~clkF;
  end

  task automatic step();
    @(posedge clkF);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4, input logic v);
    total++;
    if (PCF !== pc) begin bad++; $display("FAIL %s PCF act=%h exp=%h", nm, PCF, pc); end
    total++;
    if (instrD !== ins) begin bad++; $display("FAIL %s instrD act=%h exp=%h", nm, instrD, ins); end
    total++;
    if (PCPlus4D !== p4) begin bad++; $display("FAIL %s PCPlus4D act=%h exp=%h", nm, PCPlus4D, p4); end
    total++;
    if (ValidD !== v) begin bad++; $display("FAIL %s ValidD act=%b exp=%b", nm, ValidD, v); end
  endtask

  task automatic chk_cnt(input string nm, input logic [31:0] sc, input logic [31:0] fc);
    logic [31:0] es, ef;
    es = PERF ? sc : 32'h0;
    ef = PERF ? fc : 32'h0;
    total++;
    if (StallCntF !== es) begin bad++; $display("FAIL %s StallCntF act=%0d exp=%0d", nm, StallCntF, es); end
    total++;
    if (FlushCntF !== ef) begin bad++; $display("FAIL %s FlushCntF act=%0d exp=%0d", nm, FlushCntF, ef); end
  endtask

  task automatic test_reset();
    rstF = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    PCBranchD = 32'h0; PCjumpD = 32'h0;
    #2;
    chk_state("reset_async", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("reset_async", 32'h0, 32'h0);
    step(); step();
    chk_state("reset_held", 32'h0, 32'h0, 32'h0, 1'b0);
    rstF = 1'b1;
    chk_state("release_first", 32'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_state("seq", 32'(4 * i), mem_word(32'(4 * (i - 1))), 32'(4 * i), 1'b1);
    end
  endtask

  task automatic test_branch();
    step();
    chk_state("br_pre", 32'h10, mem_word(32'hC), 32'h10, 1'b1);
    PCSrcD = 1'b1; PCBranchD = 32'h40;
    step();
    PCSrcD = 1'b0;
    chk_state("br_bubble", 32'h40, 32'h0, 32'h0, 1'b0);
    chk_cnt("br_bubble", 32'h0, 32'h1);
    step();
    chk_state("br_target", 32'h44, mem_word(32'h40), 32'h44, 1'b1);
  endtask

  task automatic test_jump_conflict();
    JumpD = 1'b1; PCSrcD = 1'b1; PCjumpD = 32'h100; PCBranchD = 32'h80;
    step();
    JumpD = 1'b0; PCSrcD = 1'b0;
    chk_state("jmp_bubble", 32'h100, 32'h0, 32'h0, 1'b0);
    chk_cnt("jmp_bubble", 32'h0, 32'h2);
    step();
    chk_state("jmp_target", 32'h104, mem_word(32'h100), 32'h104, 1'b1);
  endtask

  task automatic test_stall_precedence();
    #2;
    rstF = 1'b0;
    #1;
    chk_state("reset_mid", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("reset_mid", 32'h0, 32'h0);
    step();
    rstF = 1'b1;
    step();
    chk_state("stall_pre", 32'h4, mem_word(32'h0), 32'h4, 1'b1);
    StallF = 1'b1; StallD = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h200;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_state("stall_hold", 32'h4, mem_word(32'h0), 32'h4, 1'b1);
    end
    chk_cnt("stall_hold", 32'h3, 32'h0);
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0;
    step();
    chk_state("stall_resume", 32'h8, mem_word(32'h4), 32'h8, 1'b1);
  endtask

  task automatic test_split_stall();
    StallF = 1'b1; StallD = 1'b0; PCSrcD = 1'b1; PCBranchD = 32'h300;
    step();
    StallF = 1'b0; PCSrcD = 1'b0;
    chk_state("split_flush", 32'h8, 32'h0, 32'h0, 1'b0);
    chk_cnt("split_flush", 32'h4, 32'h1);
    step();
    chk_state("split_resume", 32'hC, mem_word(32'h8), 32'hC, 1'b1);
  endtask

  task automatic test_wrap();
    JumpD = 1'b1; PCjumpD = 32'hFFFF_FFFC;
    step();
    JumpD = 1'b0;
    chk_state("wrap_jump", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    step();
    chk_state("wrap_over", 32'h0, mem_word(32'hFFFF_FFFC), 32'h0, 1'b1);
    JumpD = 1'b1; PCjumpD = 32'h103;
    step();
    JumpD = 1'b0;
    chk_state("unaligned", 32'h103, 32'h0, 32'h0, 1'b0);
    step();
    chk_state("unaligned_next", 32'h107, mem_word(32'h103), 32'h107, 1'b1);
    chk_cnt("wrap_end", 32'h4, 32'h3);
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump_conflict();
    test_stall_precedence();
    test_split_stall();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the decode stage. It owns the program counter, selects the next PC from PC+4, the decode-stage branch target or the decode-stage jump target, and drives the separate instruction-memory port. It captures the fetched word and PC+4 into the IF/ID pipeline register, with hazard-unit stall and redirect-flush control.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word inserted into instrD on reset and flush (sll $0,$0,0).

Ports:
- clkF  input  1  stage clock; all state updates on rising edge.
- rstF  input  1  asynchronous, active-low reset.
- StallF  input  1  hazard unit: hold PC.
- StallD  input  1  hazard unit: hold IF/ID register.
- PCSrcD  input  1  taken branch resolved in decode.
- JumpD  input  1  jump resolved in decode.
- PCBranchD  input  32  branch target from decode.
- PCjumpD  input  32  jump target from decode.
- InstrF  input  32  instruction-memory read data for address PCF, same cycle (combinational memory).
- PCF  output  32  current fetch address to instruction memory.
- instrD  output  32  IF/ID instruction to decode.
- PCPlus4D  output  32  IF/ID PC+4 to decode.
- ValidD  output  1  instrD holds a real fetched instruction (0 = bubble).
- StallCntF  output  32  stall-cycle counter (see Configuration).
- FlushCntF  output  32  applied-flush counter (see Configuration).

## Operation
- PCPlus4F = PCF + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Next-PC priority: JumpD → PCjumpD; else PCSrcD → PCBranchD; else PCPlus4F. JumpD and PCSrcD both high: jump wins.
- PC register: StallF=1 holds PCF, overriding any redirect. StallF=0 loads next-PC.
- Redirect = PCSrcD | JumpD.
- IF/ID register, evaluated in priority order:
  - StallD=1: hold instrD, PCPlus4D and ValidD. Stall overrides flush.
  - Redirect=1: load instrD=NOP_INSTR, PCPlus4D=0 and ValidD=0. This discards the wrong-path word fetched this cycle.
  - Otherwise: load instrD=InstrF, PCPlus4D=PCPlus4F and ValidD=1.
- No alignment checking. PCF[1:0] follows the target's low bits unchanged.
- Reset (any time, including mid-stall or mid-redirect) forces immediately, without waiting for a clock edge:
  - PCF=RESET_PC, instrD=NOP_INSTR, PCPlus4D=0, ValidD=0.
  - StallCntF=0, FlushCntF=0.
  - Release takes effect at the first rising edge with rstF=1.

## Timing
- PCF and all outputs are registered. There is no combinational path from inputs to outputs.
- Fetch latency: address PCF presented in cycle n; the word appears on instrD after the edge ending cycle n.
- Redirect penalty: redirect asserted in cycle n gives PCF=target and instrD=bubble in cycle n+1. The target instruction reaches instrD in cycle n+2, i.e. one bubble.
- A stall held for k cycles freezes PCF/instrD for k cycles. On the first unstalled edge, fetch resumes from the held PCF with no lost or duplicated instruction.
- First cycle after reset release: PCF=RESET_PC and ValidD=0. After the next edge, instrD=mem[RESET_PC] and ValidD=1.

## Configuration
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - StallCntF increments on every edge with StallF=1.
  - FlushCntF increments on every edge with Redirect=1 and StallD=0, i.e. a flush actually applied.
  - Both counters saturate at 32'hFFFF_FFFF and clear only on reset.
- Undefined: both ports are tied to 32'h0, no counter flops are generated, and all other behaviour is identical.

## Test plan
- Reset/sequential: rstF low mid-cycle, then released, with mem[i]=i.
  - Required: PCF=0 while reset; then 0,4,8,…
  - instrD lags PCF by one cycle; ValidD rises one cycle after release.
- Branch flush: PCSrcD=1 for one cycle with PCBranchD=32'h40 while PCF=32'h10.
  - Next cycle: PCF=32'h40, instrD=0, ValidD=0.
  - Following cycle: instrD=mem[32'h40], PCPlus4D=32'h44.
- Jump/branch conflict: JumpD=1 and PCSrcD=1 with PCjumpD=32'h100 and PCBranchD=32'h80.
  - Required: PCF=32'h100, and with the counter enabled FlushCntF increments by 1.
- Stall precedence: StallF=StallD=1 for 3 cycles with PCSrcD=1 throughout.
  - Required: PCF, instrD and ValidD are unchanged; StallCntF=3 and FlushCntF=0.
- Wrap-around: force PCF=32'hFFFF_FFFC via a jump.
  - Required: next PCF=0 and PCPlus4D=0 with ValidD=1.
- Build without FETCH_PERF_CNT_EN: rerun the stall-precedence stimulus.
  - Required: StallCntF=FlushCntF=0 at all times; all other outputs match the enabled build.
